// File: rtl/md_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: op encodings,
// FSM state encoding and the default operand width.
package md_pkg;

  localparam int MD_XLEN = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } md_state_t;

endpackage

// File: rtl/md_restoring_div.sv
// Restoring divider datapath: one quotient bit per i_step, operands on i_load.
// Unsigned magnitudes in; a zero divisor yields all-ones quotient, remainder = dividend.
module md_restoring_div #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quo,
  output logic [XLEN-1:0] o_rem
);

  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;

  // The dividend is shifted out of the quotient register MSB-first while
  // quotient bits are shifted in at the bottom.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (i_load) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_dvs <= i_divisor;
    end else if (i_step) begin
      if (!w_diff[XLEN]) begin
        r_rem <= w_diff[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], 1'b0};
      end
    end
  end

  assign o_quo = r_quo;
  assign o_rem = r_rem;

endmodule

// File: rtl/md_unit.sv
// EXE-stage multiply/divide unit: ITER iteration cycles + FIX + DONE (result pulse).
// Start is only taken in IDLE; cancel aborts an operation in flight without touching HI/LO.
module md_unit
  import md_pkg::*;
#(
  parameter int XLEN = MD_XLEN,
  parameter int ITER = XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [1:0]      i_alu_md,
  input  logic            i_cancel,
  input  logic [XLEN-1:0] i_rs_data,
  input  logic [XLEN-1:0] i_rt_data,
  output logic            o_mult_busy,
  output logic            o_div_busy,
  output logic            o_keep_md,
  output logic            o_mult_over,
  output logic            o_div_over,
  output logic            o_md_cs,
  output logic [XLEN-1:0] o_hi_data,
  output logic [XLEN-1:0] o_lo_data
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  md_state_t         r_state;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_mcand;
  logic              r_neg_a, r_neg_b, r_dz;
  logic              r_mult_busy, r_div_busy, r_mult_over, r_div_over, r_md_cs;
  logic [XLEN-1:0]   r_hi, r_lo;

  logic              w_signed, w_rs_neg, w_rt_neg, w_go, w_div_load, w_div_step, w_negp;
  logic [XLEN-1:0]   w_rs_mag, w_rt_mag, w_dq, w_dr, w_quo, w_rem;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_prod;

  assign w_signed   = ~i_alu_md[0];
  assign w_rs_neg   = w_signed & i_rs_data[XLEN-1];
  assign w_rt_neg   = w_signed & i_rt_data[XLEN-1];
  assign w_rs_mag   = w_rs_neg ? -i_rs_data : i_rs_data;
  assign w_rt_mag   = w_rt_neg ? -i_rt_data : i_rt_data;
  assign w_go       = (r_state == S_IDLE) & i_start & ~i_cancel;
  assign w_div_load = w_go & i_alu_md[1];
  assign w_div_step = (r_state == S_DIV) & ~i_cancel;

  md_restoring_div #(.XLEN(XLEN)) u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_div_load),
    .i_step     (w_div_step),
    .i_dividend (w_rs_mag),
    .i_divisor  (w_rt_mag),
    .o_quo      (w_dq),
    .o_rem      (w_dr)
  );

  // Shift-add: low half starts as the multiplier and is consumed LSB-first.
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_mcand : {XLEN{1'b0}})};

  // Divide by zero keeps an all-ones quotient regardless of operand signs.
  assign w_negp = r_neg_a ^ r_neg_b;
  assign w_prod = w_negp ? -r_acc : r_acc;
  assign w_quo  = (w_negp & ~r_dz) ? -w_dq : w_dq;
  assign w_rem  = r_neg_a ? -w_dr : w_dr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_neg_a     <= 1'b0;
      r_neg_b     <= 1'b0;
      r_dz        <= 1'b0;
      r_mult_busy <= 1'b0;
      r_div_busy  <= 1'b0;
      r_mult_over <= 1'b0;
      r_div_over  <= 1'b0;
      r_md_cs     <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      r_mult_over <= 1'b0;
      r_div_over  <= 1'b0;
      r_md_cs     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_state     <= i_alu_md[1] ? S_DIV : S_MUL;
            r_mult_busy <= ~i_alu_md[1];
            r_div_busy  <= i_alu_md[1];
            r_neg_a     <= w_rs_neg;
            r_neg_b     <= w_rt_neg;
            r_dz        <= (i_rt_data == '0);
            r_mcand     <= w_rs_mag;
            r_acc       <= {{XLEN{1'b0}}, w_rt_mag};
            r_cnt       <= '0;
          end
        end
        S_MUL, S_DIV: begin
          if (i_cancel) begin
            r_state     <= S_IDLE;
            r_mult_busy <= 1'b0;
            r_div_busy  <= 1'b0;
          end else begin
            if (r_state == S_MUL) r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
            if (r_cnt == LAST) begin
              r_state <= S_FIX;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_FIX: begin
          r_mult_busy <= 1'b0;
          r_div_busy  <= 1'b0;
          if (i_cancel) begin
            r_state <= S_IDLE;
          end else begin
            r_state     <= S_DONE;
            r_mult_over <= r_mult_busy;
            r_div_over  <= r_div_busy;
            r_md_cs     <= 1'b1;
            r_hi        <= r_div_busy ? w_rem : w_prod[2*XLEN-1:XLEN];
            r_lo        <= r_div_busy ? w_quo : w_prod[XLEN-1:0];
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mult_busy = r_mult_busy;
  assign o_div_busy  = r_div_busy;
  assign o_keep_md   = r_mult_busy | r_div_busy;
  assign o_mult_over = r_mult_over;
  assign o_div_over  = r_div_over;
  assign o_md_cs     = r_md_cs;
  assign o_hi_data   = r_hi;
  assign o_lo_data   = r_lo;

endmodule
